// File: rtl/mskaes_out_serializer_pkg.sv
// Shared definitions for the masked AES ciphertext output serializer:
// FSM state encoding and helpers deriving beat count and counter width
// from the unmasked word width W.
package mskaes_out_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Number of W-bit words in one 128-bit ciphertext.
  function automatic int beats_f(input int w);
    return 128 / w;
  endfunction

  // Beat counter width; at least one bit even when a ciphertext is one beat.
  function automatic int cnt_w_f(input int w);
    return ((128 / w) > 1) ? $clog2(128 / w) : 1;
  endfunction

endpackage

// File: rtl/mskaes_out_serializer_if.sv
// Handshake bundle of the serializer: ciphertext input side from the AES
// core and the W-bit masked word stream towards the consumer.
// The slave view belongs to the serializer, the master view to its neighbours.
interface mskaes_out_serializer_if #(
  parameter int d = 2,
  parameter int W = 32
);

  (* fv_type = "sharing" *) logic [128*d-1:0] sh_ciphertext;
  logic                                       cipher_valid;
  logic                                       out_ready;
  (* fv_type = "sharing" *) logic [W*d-1:0]   sh_data_out;
  logic                                       data_valid;
  logic                                       data_ready;
  logic                                       data_last;
  logic                                       busy;

  modport master (
    output sh_ciphertext, cipher_valid, data_ready,
    input  out_ready, sh_data_out, data_valid, data_last, busy
  );

  modport slave (
    input  sh_ciphertext, cipher_valid, data_ready,
    output out_ready, sh_data_out, data_valid, data_last, busy
  );

endinterface

// File: rtl/mskaes_out_serializer_sh_shift_reg.sv
// Shift register for a bit-compact sharing: loads a whole sharing, or shifts
// it right by one step-bit word (step*d wires) with zero fill, else holds.
// Only the lowest word is exported so shares never leave as a full vector.
module msk_sh_shift_reg #(
  parameter int d     = 2,
  parameter int count = 128,
  parameter int step  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [count*d-1:0]    din,
  output logic [step*d-1:0]     head
);

  logic [count*d-1:0] sh_q;

  // Load has priority over shift; shifting in zeros empties the register
  // as the last word leaves, so no stale share lingers after a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= din;
    end else if (shift) begin
      sh_q <= sh_q >> (step * d);
    end
  end

  assign head = sh_q[step*d-1:0];

endmodule

// File: rtl/mskaes_out_serializer.sv
// Masked AES-128 ciphertext serializer: takes one bit-compact 128-bit
// sharing from the core and streams it as BEATS masked W-bit words,
// word 0 first, with back-to-back acceptance on the final beat.
// Shares are never recombined; the output is zeroed whenever not valid.
(* fv_prop = "PINI", fv_strategy = "composite" *)
module mskaes_out_serializer
  import mskaes_out_serializer_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 32
) (
  input logic                    clk,
  input logic                    rst,
  mskaes_out_serializer_if.slave bus
);

  localparam int BEATS = beats_f(W);
  localparam int CNT_W = cnt_w_f(W);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W*d-1:0]   head;
  logic             send;
  logic             last_beat;
  logic             beat_hs;
  logic             accept;

  assign send      = (state == ST_SEND);
  assign last_beat = send && (cnt == CNT_W'(BEATS - 1));
  assign beat_hs   = send && bus.data_ready;
  assign accept    = bus.cipher_valid && bus.out_ready;

  // The core may hand over a new ciphertext while idle or exactly on the
  // final beat handshake; this is the accepted data_ready->out_ready path.
  assign bus.out_ready = (state == ST_IDLE) || (last_beat && bus.data_ready);

  msk_sh_shift_reg #(
    .d     (d),
    .count (128),
    .step  (W)
  ) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (beat_hs),
    .din   (bus.sh_ciphertext),
    .head  (head)
  );

  // Transfer control: count beats in SEND and either reload on the last
  // handshake (when the core is ready with the next ciphertext) or go idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cipher_valid) begin
            state <= ST_SEND;
            cnt   <= '0;
          end
        end
        ST_SEND: begin
          if (beat_hs) begin
            if (last_beat) begin
              cnt   <= '0;
              state <= bus.cipher_valid ? ST_SEND : ST_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data_valid = send;
  assign bus.data_last  = last_beat;
  assign bus.busy       = send;

  // Zero-constant mux gating: no share value reaches the consumer unless
  // a beat is actually being offered.
  assign bus.sh_data_out = send ? head : '0;

endmodule

// File: doc/mskaes_out_serializer.md
Name: mskaes_out_serializer

Overview:
- Sits directly downstream of the masked AES-128 32-bit core.
- Consumes the full 128-bit masked ciphertext (bit-compact sharing) through the core's cipher_valid/out_ready handshake.
- Streams it out as W-bit masked words (W*d wires per beat) over a valid/ready/last interface.
- Shares are never recombined. Non-valid output is forced to zero so no residual share leaks to the consumer.

Parameters:
- d, 2, number of shares; bit i of a value occupies bits [i*d +: d].
- W, 32, unmasked bits per output beat; must divide 128 (legal values 8, 16, 32, 64, 128).

Ports:
- clk  in  1  clock; all flops rising edge.
- rst  in  1  reset, asynchronous and active-low.
- sh_ciphertext  in  128*d  masked ciphertext from the core, bit-compact.
- cipher_valid  in  1  core ciphertext valid.
- out_ready  out  1  to the core; a ciphertext is taken when cipher_valid && out_ready.
- sh_data_out  out  W*d  current masked word, bit-compact; all zeros when data_valid=0.
- data_valid  out  1  beat valid.
- data_ready  in  1  consumer accepts the beat.
- data_last  out  1  high with the final beat (index BEATS-1) of a ciphertext.
- busy  out  1  high while in SEND.

Behaviour:
- BEATS=128/W. Word k = sh_ciphertext[k*W*d +: W*d], i.e. unmasked bits k*W..k*W+W-1. Word 0 is sent first.
- FSM has two states, IDLE and SEND. cnt is CNT_W bits; buf is a 128*d-bit shift register.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, buf=0.
- Reset values of outputs: out_ready=1, data_valid=0, data_last=0, busy=0, sh_data_out=0.
- IDLE behaviour:
  - Outputs: out_ready=1, data_valid=0.
  - On cipher_valid=1: buf<=sh_ciphertext, cnt<=0, go to SEND.
- SEND behaviour:
  - Outputs: data_valid=1, sh_data_out=buf[0 +: W*d], data_last=(cnt==BEATS-1), busy=1.
  - Beat handshake is data_valid && data_ready. On a handshake:
    - buf shifts right by W*d with zero fill.
    - cnt increments.
  - On the handshake where data_last=1:
    - cnt<=0.
    - If cipher_valid=1, buf<=sh_ciphertext and stay in SEND (back-to-back, no bubble).
    - Otherwise go to IDLE. buf is already all zeros at this point.
- out_ready is defined as (state==IDLE) || (state==SEND && data_last && data_ready).
  - This is a combinational data_ready->out_ready path and is accepted.
  - out_ready does not depend on cipher_valid.
- Backpressure: while data_ready=0 in SEND, buf, cnt and all outputs hold. data_valid never drops before its handshake.
- Latency: ciphertext accepted at edge N gives beat 0 valid in cycle N+1. Minimum BEATS cycles per ciphertext. Sustained throughput is 1 beat/cycle.
- sh_data_out is gated by data_valid through MSKcst/MSKmux (zero constant), same as the core's output gating.
- cipher_valid=1 while in SEND but not on the last handshake: not accepted. The core holds its ciphertext because out_ready=0.
- Reset mid-SEND: the transfer is aborted immediately and buf is zeroed. No partial beat is re-emitted after reset.
- W=128 (BEATS=1): every beat is last. cnt is a constant 0 (CNT_W=1).
- Formal composition: the block holds only sharings and control. Annotate it fv_prop PINI, strategy composite, with sh ports fv_type sharing.

Decomposition:
- Shared package / include holds:
  - BEATS=128/W;
  - CNT_W=max(1,$clog2(BEATS));
  - FSM state encodings ST_IDLE=1'b0, ST_SEND=1'b1.
- One natural sub-module, msk_sh_shift_reg, parameterised by (d, count=128, step=W):
  - load (priority), shift with zero fill, hold;
  - flops with asynchronous active-low reset to zero.
- The top level holds the FSM, cnt and the output gating mux.

Test Plan:
- Single transfer (d=2, W=32).
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, share0 = ciphertext ^ r, share1 = r, r = 0xA5 repeated.
  - Required: data_valid rises 1 cycle after accept. Recombined beats are 70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8. data_last only on the 4th beat. sh_data_out=0 afterwards.
- Backpressure.
  - Stimulus: data_ready toggles 1,0,0,1,0,1,1.
  - Required: each beat is stable while stalled. Exactly 4 handshakes occur. out_ready=0 until the last handshake.
- Back-to-back.
  - Stimulus: second ciphertext 00112233445566778899aabbccddeeff held valid; data_ready=1 throughout.
  - Required: 8 consecutive beats with no gap. Beat 4 recombines to ccddeeff. out_ready pulses in the cycle of beat 3.
- Reset mid-operation.
  - Stimulus: assert rst=0 asynchronously after beat 1.
  - Required: data_valid=0, sh_data_out=0 and out_ready=1 immediately. The next accepted ciphertext restarts at word 0.
- Leakage gating.
  - Stimulus: random sh_ciphertext with cipher_valid=0 for 20 cycles.
  - Required: sh_data_out stays at 0 and buf is never loaded.
- W=128, d=3.
  - Stimulus: one ciphertext.
  - Required: a single beat with data_last=1 whose 384-bit sharing equals the input sharing bit-exactly.
